// File: rtl/prog_fir_pkg.sv
// ============================================================================
// Module      : prog_fir_pkg
// Description : Shared types and default sizes for the programmable-FIR
//               coefficient loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package prog_fir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_PENDING = 2'd3
   } state_t;

   localparam int COEFFS_PER_WORD = 2;
   localparam int DEF_N_TAPS      = 30;
   localparam int DEF_COEFF_W     = 16;
   localparam int DEF_ADDR_W      = 10;

endpackage

`default_nettype wire

// File: rtl/prog_fir_coeff_loader_coeff_rd_pipe.sv
// ============================================================================
// Module      : coeff_rd_pipe
// Description : RD_LAT-deep valid/index delay line; tags RAM read data with
//               the word index that was issued RD_LAT cycles earlier.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module coeff_rd_pipe #(
   parameter int RD_LAT = 2,
   parameter int IDX_W  = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_vld,
   input  logic [IDX_W-1:0] i_idx,
   output logic             o_vld,
   output logic [IDX_W-1:0] o_idx
);

   logic [RD_LAT-1:0] r_vld;
   logic [IDX_W-1:0]  r_idx [RD_LAT];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            r_idx[s] <= '0;
         end
      end else begin
         r_vld[0] <= i_vld;
         r_idx[0] <= i_idx;
         for (int s = 1; s < RD_LAT; s++) begin
            r_vld[s] <= r_vld[s-1];
            r_idx[s] <= r_idx[s-1];
         end
      end
   end

   assign o_vld = r_vld[RD_LAT-1];
   assign o_idx = r_idx[RD_LAT-1];

endmodule

`default_nettype wire

// File: rtl/prog_fir_coeff_loader.sv
// ============================================================================
// Module      : prog_fir_coeff_loader
// Description : Reads packed tap coefficients from RAM port A into a shadow
//               bank and swaps it into the active bank on a frame boundary.
//               Optional macro PROG_FIR_CKSUM_EN builds a per-load checksum.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_fir_coeff_loader
   import prog_fir_pkg::*;
#(
   parameter int N_TAPS  = DEF_N_TAPS,
   parameter int COEFF_W = DEF_COEFF_W,
   parameter int RD_LAT  = 2,
   parameter int ADDR_W  = DEF_ADDR_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_load,
   input  logic [ADDR_W-1:0]         i_base_addr,
   input  logic                      i_frame_sync,
   output logic                      o_bram_en_a,
   output logic                      o_bram_we,
   output logic [ADDR_W-1:0]         o_bram_addr,
   output logic [31:0]               o_bram_wr_data,
   input  logic [31:0]               i_bram_rd_data,
   output logic [N_TAPS*COEFF_W-1:0] o_coeffs,
   output logic                      o_coeffs_valid,
   output logic                      o_busy,
   output logic                      o_done,
   output logic                      o_load_err,
   output logic [15:0]               o_load_count,
   output logic [31:0]               o_cksum
);

   localparam int C_WORDS  = N_TAPS / COEFFS_PER_WORD;
   localparam int C_WORD_W = COEFFS_PER_WORD * COEFF_W;
   localparam int C_IDX_W  = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_WORDS - 1);

   state_t                    r_state;
   logic                      r_en_a;
   logic [ADDR_W-1:0]         r_addr;
   logic [C_IDX_W-1:0]        r_idx;
   logic [N_TAPS*COEFF_W-1:0] r_coeffs;
   logic                      r_coeffs_valid;
   logic                      r_done;
   logic                      r_load_err;
   logic [15:0]               r_load_count;
   logic [C_WORD_W-1:0]       r_shadow [C_WORDS];

   logic                      w_cap_vld;
   logic [C_IDX_W-1:0]        w_cap_idx;
   logic                      w_accept;
   logic                      w_swap;

   assign w_accept = (r_state == ST_IDLE) && i_load;
   assign w_swap   = (r_state == ST_PENDING) && i_frame_sync;

   // Index tag travels alongside the address so the returning word lands
   // in the right shadow slot regardless of RD_LAT.
   coeff_rd_pipe #(
      .RD_LAT (RD_LAT),
      .IDX_W  (C_IDX_W)
   ) u_rd_pipe (
      .clk   (clk),
      .rst   (rst),
      .i_vld (r_en_a),
      .i_idx (r_idx),
      .o_vld (w_cap_vld),
      .o_idx (w_cap_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < C_WORDS; k++) begin
            r_shadow[k] <= '0;
         end
      end else if (w_cap_vld) begin
         r_shadow[w_cap_idx] <= i_bram_rd_data[C_WORD_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state        <= ST_IDLE;
         r_en_a         <= 1'b0;
         r_addr         <= '0;
         r_idx          <= '0;
         r_coeffs       <= '0;
         r_coeffs_valid <= 1'b0;
         r_done         <= 1'b0;
         r_load_err     <= 1'b0;
         r_load_count   <= '0;
      end else begin
         r_done <= 1'b0;
         if (i_load && (r_state != ST_IDLE)) begin
            r_load_err <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr  <= i_base_addr;
                  r_en_a  <= 1'b1;
                  r_idx   <= '0;
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (r_idx == C_LAST_IDX) begin
                  r_en_a  <= 1'b0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_addr <= r_addr + 1'b1;
                  r_idx  <= r_idx + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (w_cap_vld && (w_cap_idx == C_LAST_IDX)) begin
                  r_state <= ST_PENDING;
               end
            end
            ST_PENDING: begin
               if (w_swap) begin
                  for (int k = 0; k < C_WORDS; k++) begin
                     r_coeffs[k*C_WORD_W +: C_WORD_W] <= r_shadow[k];
                  end
                  r_done         <= 1'b1;
                  r_coeffs_valid <= 1'b1;
                  r_load_count   <= r_load_count + 16'd1;
                  r_state        <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef PROG_FIR_CKSUM_EN
   logic [31:0] r_acc;
   logic [31:0] r_cksum;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc   <= '0;
         r_cksum <= '0;
      end else begin
         if (w_accept) begin
            r_acc <= '0;
         end else if (w_cap_vld) begin
            r_acc <= r_acc + i_bram_rd_data;
         end
         if (w_swap) begin
            r_cksum <= r_acc;
         end
      end
   end

   assign o_cksum = r_cksum;
`else
   assign o_cksum = '0;
`endif

   assign o_bram_en_a    = r_en_a;
   assign o_bram_we      = 1'b0;
   assign o_bram_addr    = r_addr;
   assign o_bram_wr_data = '0;
   assign o_coeffs       = r_coeffs;
   assign o_coeffs_valid = r_coeffs_valid;
   assign o_busy         = (r_state != ST_IDLE);
   assign o_done         = r_done;
   assign o_load_err     = r_load_err;
   assign o_load_count   = r_load_count;

endmodule

`default_nettype wire

// File: tb/tb_prog_fir_coeff_loader.sv
// ============================================================================
// Module      : tb_prog_fir_coeff_loader
// Description : Self-checking bench with a RAM model and a tap-level model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_prog_fir_coeff_loader;

   localparam int N_TAPS  = 30;
   localparam int COEFF_W = 16;
   localparam int RD_LAT  = 2;
   localparam int ADDR_W  = 10;
   localparam int W       = N_TAPS / 2;
   localparam int TW      = N_TAPS * COEFF_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              load;
   logic [ADDR_W-1:0] base_addr;
   logic              frame_sync;
   logic              bram_en_a;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [31:0]       bram_wr_data;
   logic [31:0]       bram_rd_data;
   logic [TW-1:0]     coeffs;
   logic              coeffs_valid;
   logic              busy;
   logic              done;
   logic              load_err;
   logic [15:0]       load_count;
   logic [31:0]       cksum;

   always #5 clk = ~clk;

   prog_fir_coeff_loader #(
      .N_TAPS (N_TAPS), .COEFF_W (COEFF_W), .RD_LAT (RD_LAT), .ADDR_W (ADDR_W)
   ) dut (
      .clk (clk), .rst (rst), .i_load (load), .i_base_addr (base_addr),
      .i_frame_sync (frame_sync), .o_bram_en_a (bram_en_a), .o_bram_we (bram_we),
      .o_bram_addr (bram_addr), .o_bram_wr_data (bram_wr_data),
      .i_bram_rd_data (bram_rd_data), .o_coeffs (coeffs),
      .o_coeffs_valid (coeffs_valid), .o_busy (busy), .o_done (done),
      .o_load_err (load_err), .o_load_count (load_count), .o_cksum (cksum)
   );

   // RAM port A: two-cycle read latency, garbage when not enabled
   logic [31:0] mem [0:1023];
   logic [31:0] ram_p1, ram_p2;
   always @(posedge clk) begin
      ram_p1 <= bram_en_a ? mem[bram_addr] : 32'hDEAD_BEEF;
      ram_p2 <= ram_p1;
   end
   assign bram_rd_data = ram_p2;

   int                tests = 0;
   int                fails = 0;
   int                done_cnt = 0;
   int                exp_count = 0;
   logic [TW-1:0]     exp_active = '0;
   logic [ADDR_W-1:0] addr_q [$];

   always @(negedge clk) begin
      if (bram_en_a) addr_q.push_back(bram_addr);
      if (done) done_cnt++;
   end

   function automatic logic [TW-1:0] model_taps(input int base);
      logic [TW-1:0] res;
      logic [31:0]   word;
      res = '0;
      for (int i = 0; i < W; i++) begin
         word = mem[(base + i) % 1024];
         res[(2*i)*COEFF_W   +: COEFF_W] = word[15:0];
         res[(2*i+1)*COEFF_W +: COEFF_W] = word[31:16];
      end
      return res;
   endfunction

   function automatic logic [31:0] model_cksum(input int base);
      logic [31:0] s;
      s = 32'd0;
`ifdef PROG_FIR_CKSUM_EN
      for (int i = 0; i < W; i++) s = s + mem[(base + i) % 1024];
`endif
      return s;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_random();
      for (int a = 0; a < 1024; a++) mem[a] = $urandom;
   endtask

   task automatic start_load(input int base);
      addr_q.delete();
      base_addr = ADDR_W'(base);
      load = 1'b1;
      tick();
      load = 1'b0;
      base_addr = ADDR_W'($urandom);
   endtask

   task automatic finish_load(input int delay);
      for (int i = 0; i < delay; i++) tick();
      frame_sync = 1'b1;
      tick();
      frame_sync = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick(); tick();
      rst = 1'b0;
      exp_count = 0; exp_active = '0;
      tests++; if (coeffs !== '0) begin fails++; $display("FAIL reset_coeffs got %h exp 0", coeffs); end
      tests++; if ({coeffs_valid, busy, done, load_err} !== 4'b0) begin fails++; $display("FAIL reset_flags got %b exp 0000", {coeffs_valid, busy, done, load_err}); end
      tests++; if (load_count !== 16'd0 || cksum !== 32'd0) begin fails++; $display("FAIL reset_counts got cnt=%0d ck=%h exp 0", load_count, cksum); end
      tests++; if (bram_en_a !== 1'b0 || bram_addr !== '0) begin fails++; $display("FAIL reset_bram got en=%b addr=%0d exp 0", bram_en_a, bram_addr); end
   endtask

   task automatic test_basic();
      logic [TW-1:0] exp_t;
      int            bad;
      for (int i = 0; i < W; i++) mem[i] = {16'(2*i + 2), 16'(2*i + 1)};
      for (int k = 0; k < N_TAPS; k++) exp_t[k*COEFF_W +: COEFF_W] = 16'(k + 1);
      done_cnt = 0;
      start_load(0);
      for (int i = 0; i < 39; i++) tick();
      tests++; if (busy !== 1'b1 || coeffs !== '0) begin fails++; $display("FAIL basic_preswap got busy=%b coeffs=%h exp busy=1 coeffs=0", busy, coeffs); end
      finish_load(0);
      exp_count++; exp_active = exp_t;
      tests++; if (coeffs !== exp_t) begin fails++; $display("FAIL basic_taps got %h exp %h", coeffs, exp_t); end
      tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL basic_done got done=%b busy=%b exp 1/0", done, busy); end
      tick(); tick();
      tests++; if (done_cnt !== 1) begin fails++; $display("FAIL basic_done_width got %0d exp 1", done_cnt); end
      tests++; if (load_count !== 16'd1 || coeffs_valid !== 1'b1) begin fails++; $display("FAIL basic_count got cnt=%0d vld=%b exp 1/1", load_count, coeffs_valid); end
      tests++; if (cksum !== model_cksum(0)) begin fails++; $display("FAIL basic_cksum got %h exp %h", cksum, model_cksum(0)); end
      bad = (addr_q.size() != W) ? 1 : 0;
      for (int i = 0; i < addr_q.size() && i < W; i++) if (addr_q[i] !== ADDR_W'(i)) bad = 1;
      tests++; if (bad != 0) begin fails++; $display("FAIL basic_addrs got %0d addrs exp %0d from 0", addr_q.size(), W); end
      tests++; if (bram_we !== 1'b0 || bram_wr_data !== 32'd0) begin fails++; $display("FAIL bram_write got we=%b wd=%h exp 0", bram_we, bram_wr_data); end
   endtask

   task automatic test_wrap();
      int bad;
      fill_random();
      start_load(1020);
      finish_load(20);
      exp_count++; exp_active = model_taps(1020);
      tests++; if (coeffs !== exp_active) begin fails++; $display("FAIL wrap_taps got %h exp %h", coeffs, exp_active); end
      bad = (addr_q.size() != W) ? 1 : 0;
      for (int i = 0; i < addr_q.size() && i < W; i++) if (addr_q[i] !== ADDR_W'((1020 + i) % 1024)) bad = 1;
      tests++; if (bad != 0) begin fails++; $display("FAIL wrap_addrs got %0d addrs first=%0d exp %0d from 1020", addr_q.size(), addr_q[0], W); end
      tick();
   endtask

   task automatic test_load_err();
      int b;
      fill_random();
      b = $urandom_range(0, 1023);
      start_load(b);
      for (int i = 0; i < 4; i++) tick();
      base_addr = ADDR_W'(b + 100);
      load = 1'b1;
      tick();
      load = 1'b0;
      tests++; if (load_err !== 1'b1) begin fails++; $display("FAIL load_err got %b exp 1", load_err); end
      finish_load(15);
      exp_count++; exp_active = model_taps(b);
      tests++; if (coeffs !== exp_active) begin fails++; $display("FAIL load_err_taps got %h exp %h", coeffs, exp_active); end
      tests++; if (load_count !== 16'(exp_count)) begin fails++; $display("FAIL load_err_count got %0d exp %0d", load_count, exp_count); end
      tick();
   endtask

   task automatic test_long_wait();
      int b, dc;
      fill_random();
      b = $urandom_range(0, 1023);
      start_load(b);
      for (int i = 0; i < W + RD_LAT + 200; i++) tick();
      dc = done_cnt;
      tests++; if (coeffs !== exp_active || busy !== 1'b1) begin fails++; $display("FAIL long_wait_hold got busy=%b coeffs=%h exp busy=1 coeffs=%h", busy, coeffs, exp_active); end
      tests++; if (dc !== done_cnt || done !== 1'b0) begin fails++; $display("FAIL long_wait_done got done=%b exp 0", done); end
      finish_load(0);
      exp_count++; exp_active = model_taps(b);
      tests++; if (coeffs !== exp_active || done !== 1'b1) begin fails++; $display("FAIL long_wait_swap got done=%b coeffs=%h exp done=1 coeffs=%h", done, coeffs, exp_active); end
      tick();
   endtask

   task automatic test_min_latency();
      int b, n;
      fill_random();
      b = $urandom_range(0, 1023);
      frame_sync = 1'b1;
      start_load(b);
      n = 1;
      while (done !== 1'b1 && n < 100) begin tick(); n++; end
      frame_sync = 1'b0;
      exp_count++; exp_active = model_taps(b);
      tests++; if (n != W + RD_LAT + 2) begin fails++; $display("FAIL min_latency got %0d cycles exp %0d", n, W + RD_LAT + 2); end
      tests++; if (coeffs !== exp_active) begin fails++; $display("FAIL min_latency_taps got %h exp %h", coeffs, exp_active); end
      tick();
   endtask

   task automatic test_reset_mid();
      int b;
      fill_random();
      start_load($urandom_range(0, 1023));
      for (int i = 0; i < W + 1; i++) tick();
      rst = 1'b1;
      tick();
      exp_count = 0; exp_active = '0;
      tests++; if (coeffs !== '0 || {coeffs_valid, busy, done, load_err} !== 4'b0) begin fails++; $display("FAIL rst_mid_state got flags=%b coeffs=%h exp 0", {coeffs_valid, busy, done, load_err}, coeffs); end
      tests++; if (load_count !== 16'd0 || cksum !== 32'd0 || bram_en_a !== 1'b0 || bram_addr !== '0) begin fails++; $display("FAIL rst_mid_regs got cnt=%0d ck=%h en=%b addr=%0d exp 0", load_count, cksum, bram_en_a, bram_addr); end
      rst = 1'b0;
      tick();
      fill_random();
      b = $urandom_range(0, 1023);
      start_load(b);
      finish_load(18);
      exp_count++; exp_active = model_taps(b);
      tests++; if (coeffs !== exp_active || load_count !== 16'd1) begin fails++; $display("FAIL rst_mid_reload got cnt=%0d coeffs=%h exp cnt=1 coeffs=%h", load_count, coeffs, exp_active); end
      tests++; if (cksum !== model_cksum(b)) begin fails++; $display("FAIL rst_mid_cksum got %h exp %h", cksum, model_cksum(b)); end
      tick();
   endtask

   task automatic test_cksum();
      logic [31:0] exp_ck;
      int          b;
      b = $urandom_range(0, 1023);
      for (int i = 0; i < W; i++) mem[(b + i) % 1024] = 32'hFFFF_FFFF;
`ifdef PROG_FIR_CKSUM_EN
      exp_ck = 32'hFFFF_FFF1;
`else
      exp_ck = 32'h0;
`endif
      start_load(b);
      finish_load(20);
      exp_count++; exp_active = model_taps(b);
      tests++; if (cksum !== exp_ck) begin fails++; $display("FAIL cksum_ones got %h exp %h", cksum, exp_ck); end
      tick();
   endtask

   task automatic test_random();
      int b, bad;
      for (int r = 0; r < 6; r++) begin
         fill_random();
         b = $urandom_range(0, 1023);
         start_load(b);
         finish_load((r == 0) ? 17 : $urandom_range(17, 40));
         exp_count++; exp_active = model_taps(b);
         tests++; if (coeffs !== exp_active) begin fails++; $display("FAIL rand_taps[%0d] got %h exp %h", r, coeffs, exp_active); end
         tests++; if (load_count !== 16'(exp_count) || cksum !== model_cksum(b)) begin fails++; $display("FAIL rand_count[%0d] got cnt=%0d ck=%h exp cnt=%0d ck=%h", r, load_count, cksum, exp_count, model_cksum(b)); end
         bad = (addr_q.size() != W) ? 1 : 0;
         for (int i = 0; i < addr_q.size() && i < W; i++) if (addr_q[i] !== ADDR_W'((b + i) % 1024)) bad = 1;
         tests++; if (bad != 0) begin fails++; $display("FAIL rand_addrs[%0d] got %0d addrs exp %0d from %0d", r, addr_q.size(), W, b); end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; base_addr = '0; frame_sync = 1'b0;
      for (int a = 0; a < 1024; a++) mem[a] = 32'd0;
      test_reset();
      test_basic();
      test_wrap();
      test_load_err();
      test_long_wait();
      test_min_latency();
      test_reset_mid();
      test_cksum();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/prog_fir_coeff_loader.md
# prog_fir_coeff_loader

Streams one channel's tap coefficients out of the programmable-FIR coefficient RAM (1024 × 32-bit, fabric-side port A) into a double-buffered tap register bank. The bank drives the single-channel FIR. Software writes coefficients over the bus-side RAM port and then pulses `load`. This block reads the words back, unpacks two signed coefficients per word into a shadow bank, and swaps the shadow bank into the active bank on the next FIR frame boundary. The FIR never sees a half-updated tap set.

## Interface
- `N_TAPS`, 30: FIR tap count; must be even.
- `COEFF_W`, 16: coefficient width; two per 32-bit word.
- `RD_LAT`, 2: RAM port-A read latency in cycles, from address to `bram_rd_data`.
- `ADDR_W`, 10: RAM address width.

Ports:
- `clk`  in  1: single clock for the whole block and RAM port A.
- `rst`  in  1: reset, synchronous and active-high.
- `load`  in  1: single-cycle request to start a reload.
- `base_addr`  in  ADDR_W: word address of coefficient 0; sampled on an accepted `load`.
- `frame_sync`  in  1: FIR frame boundary pulse.
- `bram_en_a`  out  1: RAM port-A enable.
- `bram_we`  out  1: RAM write enable; always 0.
- `bram_addr`  out  ADDR_W: RAM read address.
- `bram_wr_data`  out  32: always 0.
- `bram_rd_data`  in  32: RAM read data.
- `coeffs`  out  N_TAPS*COEFF_W: active taps; tap k is at bits [k*COEFF_W +: COEFF_W].
- `coeffs_valid`  out  1: high once the first swap completes; sticky until reset.
- `busy`  out  1: high in any state other than IDLE.
- `done`  out  1: one-cycle pulse on a swap.
- `load_err`  out  1: sticky; set when `load` arrives while `busy`.
- `load_count`  out  16: count of completed swaps; wraps at 65535 to 0.
- `cksum`  out  32: checksum of the last completed load (see Configuration).

## Operation
- Word i (i = 0 … W−1, with W = N_TAPS/2) is read from address (`base_addr` + i) mod 2^ADDR_W. Address wrap-around is legal.
- Word i bits [15:0] hold tap 2i. Bits [31:16] hold tap 2i+1.
- FSM states and transitions:
  - IDLE → READ on `load`.
  - READ issues one address per cycle, W cycles total, with `bram_en_a`=1. READ → DRAIN after the last address.
  - DRAIN waits RD_LAT cycles, capturing data. DRAIN → PENDING after the last word is captured.
  - PENDING: on `frame_sync`, copy the shadow bank to the active bank and go to IDLE.
- Read data is captured with a RD_LAT-deep valid/index delay line. The shadow bank writes at the returning index.
- `load` while `busy` is ignored and sets `load_err`. The load in progress is unaffected.
- `frame_sync` outside PENDING has no effect.
- Reset values: `coeffs`=0, shadow bank=0, `coeffs_valid`=0, `busy`=0, `done`=0, `load_err`=0, `load_count`=0, `cksum`=0, `bram_en_a`=0, `bram_addr`=0, state=IDLE.
- Reset mid-load aborts the load, zeroes the active bank and ignores in-flight RAM data.

## Timing
- `load` is sampled in cycle 0. Addresses are presented in cycles 1 … W.
- Data for word i is captured in cycle 1+i+RD_LAT. The last word is captured in cycle W+RD_LAT.
- PENDING is entered in cycle W+RD_LAT+1. `frame_sync` coinciding with the last capture is not used; the block waits for the next one.
- When `frame_sync` is sampled in PENDING in cycle t:
  - `coeffs`, `done`, `load_count` and `coeffs_valid` update in cycle t+1.
  - `busy` falls in cycle t+1.
- A new `load` is accepted from cycle t+1.
- Minimum load-to-swap time: W+RD_LAT+2 cycles.

## Configuration
- `PROG_FIR_CKSUM_EN` defined:
  - A 32-bit running sum (mod 2^32) of the captured words is accumulated per load.
  - It is latched to `cksum` on swap and cleared at load start.
- Undefined: `cksum` is tied to 0 and no accumulator logic is built.

## Structure
- Shared package `prog_fir_pkg` holds:
  - the state enum (IDLE, READ, DRAIN, PENDING);
  - `COEFFS_PER_WORD`=2;
  - the default `N_TAPS`, `COEFF_W` and `ADDR_W`.
- One sub-module, `coeff_rd_pipe`: the RD_LAT-deep valid/index delay line that tags returning RAM data.

## Test plan
- Preload words 0x0002_0001, 0x0004_0003, … at base 0. Pulse `load`, then `frame_sync` 40 cycles later. Expect:
  - tap k = k+1 for k = 0…29;
  - `done` for exactly 1 cycle;
  - `load_count`=1 and `coeffs_valid`=1.
- Base 1020 with W=15 → addresses 1020…1023, then 0…10. Expect the taps to match the wrapped contents.
- `load` at cycle 5 of a running load → `load_err`=1, and the first load completes with the correct taps.
- Hold `frame_sync` low for 200 cycles after the last capture → `coeffs` unchanged and `busy`=1. After the next `frame_sync`, the swap occurs in the following cycle.
- Assert `rst` during DRAIN → all outputs return to their reset values. A fresh load then completes correctly, with no stale data.
- With `PROG_FIR_CKSUM_EN`: words 0xFFFF_FFFF ×15 → `cksum` = 0xFFFF_FFF1. Without the macro, `cksum` = 0.
